wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Register-file write-back bus: port A (single-cycle results), port B
// (multi-cycle results with ready/valid) and the arbitrated write port.
// The master side is the pipeline; the slave side is the arbiter.
interface wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_wd;
    logic        stall_a;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [3:0]  pend_cnt;

    modport master (
        output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
        input  b_ready, stall_a, reg_write, rd, wd, pend_cnt
    );

    modport slave (
        input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
        output b_ready, stall_a, reg_write, rd, wd, pend_cnt
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges a non-stallable port A with a ready/valid
// port B into one registered register-file write port. B results that lose
// arbitration wait in a small in-order FIFO.
// Optional macro WB_STARVE_EN adds a starvation counter that stalls port A
// for one cycle once the FIFO head has waited STARVE_MAX cycles; without it
// stall_a is tied low and port A always has priority.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // FIFO storage, one destination and one data word per entry
    logic [4:0]    mem_rd [DEPTH];
    logic [31:0]   mem_wd [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [3:0]    pend_reg, pend_next;

    logic          reg_write_reg;
    logic [4:0]    rd_reg;
    logic [31:0]   wd_reg;
    logic          stall_reg;

    logic          b_ready;
    logic          b_keep;
    logic          fifo_ne;
    logic          a_win;
    logic          win;
    logic [4:0]    win_rd;
    logic [31:0]   win_wd;
    logic          push;
    logic          pop;

    // Ready depends only on the registered occupancy, never on this cycle's traffic
    assign b_ready = (pend_reg < DEPTH_C);
    assign b_keep  = bus.b_valid && b_ready && (bus.b_rd != 5'd0);
    assign fifo_ne = (pend_reg != 4'd0);
    assign a_win   = bus.a_valid && (bus.a_rd != 5'd0) && !stall_reg;

    // Pick the winner: A, then FIFO head, then B bypass; losing B goes to the tail
    always_comb begin
        win    = 1'b0;
        win_rd = 5'd0;
        win_wd = 32'd0;
        push   = 1'b0;
        pop    = 1'b0;
        if (a_win) begin
            win    = 1'b1;
            win_rd = bus.a_rd;
            win_wd = bus.a_wd;
            push   = b_keep;
        end else if (fifo_ne) begin
            win    = 1'b1;
            win_rd = mem_rd[rd_ptr_reg];
            win_wd = mem_wd[rd_ptr_reg];
            pop    = 1'b1;
            push   = b_keep;
        end else if (b_keep) begin
            win    = 1'b1;
            win_rd = bus.b_rd;
            win_wd = bus.b_wd;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        pend_next = pend_reg;
        if (push && !pop) begin
            pend_next = pend_reg + 4'd1;
        end else if (pop && !push) begin
            pend_next = pend_reg - 4'd1;
        end
    end

    // Registered write port, FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_reg <= 1'b0;
            rd_reg        <= 5'd0;
            wd_reg        <= 32'd0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pend_reg      <= 4'd0;
        end else begin
            reg_write_reg <= win;
            rd_reg        <= win_rd;
            wd_reg        <= win_wd;
            pend_reg      <= pend_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // FIFO entry write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_reg] <= bus.b_rd;
            mem_wd[wr_ptr_reg] <= bus.b_wd;
        end
    end

`ifdef WB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;

    logic [SW-1:0] starve_reg, starve_next;

    // Count cycles the head waits; clear when it issues or the FIFO is empty
    always_comb begin
        if (!fifo_ne || pop) begin
            starve_next = '0;
        end else begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // One-cycle stall of port A when the wait reaches its limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            starve_reg <= starve_next;
            stall_reg  <= (starve_next == SW'(STARVE_MAX));
        end
    end
`else
    assign stall_reg = 1'b0;
`endif

    assign bus.b_ready   = b_ready;
    assign bus.stall_a   = stall_reg;
    assign bus.reg_write = reg_write_reg;
    assign bus.rd        = rd_reg;
    assign bus.wd        = wd_reg;
    assign bus.pend_cnt  = pend_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst;

    wb_arbiter_if bus ();

    wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    // Reference model state
    ent_t pq[$];
    int   wait_m;
    bit   stall_m;
    bit   last_xfer;
    int   n_checks;
    int   n_errors;
    int   n_txn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One arbitration cycle: drive inputs, check pre-edge state, predict and check the write
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bwd);
        bit          br, xfer, aok, qne, issued, exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wd;
        ent_t        e;
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_wd    = awd;
        bus.b_valid = bv;
        bus.b_rd    = brd;
        bus.b_wd    = bwd;
        br = (pq.size() < DEPTH);
        #1;
        check("b_ready",  32'(bus.b_ready),  32'(br));
        check("stall_a",  32'(bus.stall_a),  32'(stall_m));
        check("pend_cnt", 32'(bus.pend_cnt), 32'(pq.size()));
        xfer   = bv && br;
        aok    = av && (ard != 5'd0) && !stall_m;
        qne    = (pq.size() > 0);
        issued = 1'b0;
        exp_we = 1'b0;
        exp_rd = 5'd0;
        exp_wd = 32'd0;
        e.rd   = brd;
        e.wd   = bwd;
        if (aok) begin
            exp_we = 1'b1; exp_rd = ard; exp_wd = awd;
            if (xfer && brd != 5'd0) pq.push_back(e);
        end else if (qne) begin
            ent_t h;
            h = pq.pop_front();
            exp_we = 1'b1; exp_rd = h.rd; exp_wd = h.wd;
            issued = 1'b1;
            if (xfer && brd != 5'd0) pq.push_back(e);
        end else if (xfer && brd != 5'd0) begin
            exp_we = 1'b1; exp_rd = brd; exp_wd = bwd;
        end
`ifdef WB_STARVE_EN
        if (!qne || issued) wait_m = 0;
        else                wait_m++;
        stall_m = (wait_m == STARVE_MAX);
`else
        if (issued) wait_m = 0;
`endif
        last_xfer = xfer;
        @(posedge clk);
        #1;
        check("reg_write", 32'(bus.reg_write), 32'(exp_we));
        if (exp_we) begin
            check("rd", 32'(bus.rd), 32'(exp_rd));
            check("wd", bus.wd, exp_wd);
        end
        n_txn++;
        $display("txn %0d a=%0b/x%0d b=%0b/x%0d xfer=%0b -> we=%0b x%0d=0x%0h pend=%0d",
                 n_txn, av, ard, bv, brd, xfer, exp_we, exp_rd, exp_wd, pq.size());
    endtask

    task automatic model_clear();
        pq.delete();
        wait_m  = 0;
        stall_m = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_wd = 32'd0;
        bus.b_valid = 1'b0; bus.b_rd = 5'd0; bus.b_wd = 32'd0;
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear before any edge
    task automatic pulse_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        #1;
        check({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
        check({tag, "_rd"},        32'(bus.rd),        32'd0);
        check({tag, "_wd"},        bus.wd,             32'd0);
        check({tag, "_stall_a"},   32'(bus.stall_a),   32'd0);
        check({tag, "_pend_cnt"},  32'(bus.pend_cnt),  32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit          bh;
        logic [4:0]  bhr;
        logic [31:0] bhw;
        logic [4:0]  offer_rd [3];
        logic [31:0] offer_wd [3];
        int          oi;
        int          first_stall;
        logic        av;

        n_checks = 0;
        n_errors = 0;
        n_txn    = 0;
        model_clear();
        last_xfer = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_pend_cnt",  32'(bus.pend_cnt),  32'd0);
        check("rst_stall_a",   32'(bus.stall_a),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // A only
        step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        check("a_only_we", 32'(bus.reg_write), 32'd1);
        check("a_only_rd", 32'(bus.rd), 32'd3);
        check("a_only_wd", bus.wd, 32'h11);

        // Collision: A first, B from FIFO one cycle later
        step(1'b1, 5'd5, 32'hAA, 1'b1, 5'd7, 32'hBB);
        check("coll_rd1",   32'(bus.rd), 32'd5);
        check("coll_wd1",   bus.wd, 32'hAA);
        check("coll_pend1", 32'(bus.pend_cnt), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("coll_rd2",   32'(bus.rd), 32'd7);
        check("coll_wd2",   bus.wd, 32'hBB);
        check("coll_pend2", 32'(bus.pend_cnt), 32'd0);

        // Zero-register A is discarded; B bypasses
        step(1'b1, 5'd0, 32'h5555, 1'b1, 5'd9, 32'h99);
        check("zero_we", 32'(bus.reg_write), 32'd1);
        check("zero_rd", 32'(bus.rd), 32'd9);
        check("zero_wd", bus.wd, 32'h99);

        // B with rd=0 accepted and dropped
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        check("b_zero_we", 32'(bus.reg_write), 32'd0);

        // Full FIFO: A busy, three B offers held until accepted
        offer_rd[0] = 5'd10; offer_wd[0] = 32'hB0;
        offer_rd[1] = 5'd11; offer_wd[1] = 32'hB1;
        offer_rd[2] = 5'd12; offer_wd[2] = 32'hB2;
        oi = 0;
        for (int i = 0; i < 4; i++) begin
            step(!stall_m, 5'd4, 32'hA0 + 32'(i), 1'b1, offer_rd[oi], offer_wd[oi]);
            if (last_xfer) oi++;
            if (i == 1) begin
                check("full_pend",  32'(bus.pend_cnt), 32'd2);
                check("full_ready", 32'(bus.b_ready),  32'd0);
            end
        end
        check("full_held", 32'(oi), 32'd2);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 32'd0, oi < 3, offer_rd[oi < 3 ? oi : 0], offer_wd[oi < 3 ? oi : 0]);
            if (last_xfer && oi < 3) oi++;
        end
        check("full_all_taken", 32'(oi), 32'd3);
        check("full_drained", 32'(bus.pend_cnt), 32'd0);

        // Starvation: continuous A, one B pending
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h22);
        first_stall = 0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.stall_a && first_stall == 0) first_stall = i;
            step(1'b1, 5'd1, 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
`ifdef WB_STARVE_EN
        check("starve_cycle", 32'(first_stall), 32'(STARVE_MAX + 1));
`else
        check("starve_none", 32'(first_stall), 32'd0);
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset mid-run with two pending entries
        step(1'b1, 5'd6, 32'h60, 1'b1, 5'd13, 32'hD0);
        step(1'b1, 5'd6, 32'h61, 1'b1, 5'd14, 32'hD1);
        check("mid_pend", 32'(bus.pend_cnt), 32'd2);
        pulse_reset("mid");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check("mid_nowrite", 32'(bus.reg_write), 32'd0);
        end

        // Randomized traffic; B source holds its offer until accepted
        bh = 1'b0; bhr = 5'd0; bhw = 32'd0;
        for (int i = 0; i < 400; i++) begin
            av = !stall_m && ($urandom_range(0, 9) < 6);
            if (!bh && $urandom_range(0, 9) < 5) begin
                bh  = 1'b1;
                bhr = 5'($urandom_range(0, 31));
                bhw = $urandom;
            end
            step(av, 5'($urandom_range(0, 31)), $urandom, bh, bhr, bhw);
            if (last_xfer) bh = 1'b0;
            if (i == 200) begin
                pulse_reset("rnd");
                bh = 1'b0;
            end
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
